srl_dly_ctrl: RTL and testbench

//  Control stage upstream of the 16-deep dynamic SRL delay bus (srl_16dxm).
//  - Converts a requested delay in clocks into the SRL tap address A.
//  - Drives the SRL shift enable.
//  - Tracks refill after every delay change, so downstream logic gets DLY_VALID qualifying the SRL output O.

---
 rtl/srl_dly_ctrl.sv | 64 ++++++
 tb/tb_srl_dly_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/srl_dly_ctrl.sv
// srl_dly_ctrl: converts a requested delay into an SRL tap address and qualifies the SRL output after refill
module srl_dly_ctrl #(
  parameter int DEFAULT_DLY = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       LOAD,
  input  logic [4:0] DLY_REQ,
  input  logic       CLR_ERR,
  output logic       SRL_CE,
  output logic [3:0] A,
  output logic [4:0] DLY_CUR,
  output logic       DLY_VALID,
  output logic       BUSY,
  output logic       CLAMP_ERR
);
  localparam logic [4:0] DEF_DLY = 5'(DEFAULT_DLY);
  localparam logic [3:0] DEF_A   = 4'(DEFAULT_DLY - 1);
  typedef enum logic {FILL, RUN} state_t;
  state_t     state;
  logic [4:0] cnt;
  logic [4:0] eff;
  logic [4:0] eff_m1;
  logic [4:0] cnt_nxt;
  logic       clamp;
  logic       change;
  // the SRL keeps shifting in every state so its contents stay current during refill
  assign SRL_CE  = CE;
  assign eff     = (DLY_REQ == 5'd0) ? 5'd1 : (DLY_REQ > 5'd16) ? 5'd16 : DLY_REQ;
  assign eff_m1  = eff - 5'd1;
  assign clamp   = eff != DLY_REQ;
  assign change  = LOAD && (eff != DLY_CUR);
  assign cnt_nxt = cnt + 5'd1;
  // delay register, refill tracking and sticky clamp flag; a delay change restarts the fill and beats its completion
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DLY_CUR   <= DEF_DLY;
      A         <= DEF_A;
      state     <= FILL;
      cnt       <= 5'd0;
      DLY_VALID <= 1'b0;
      BUSY      <= 1'b1;
      CLAMP_ERR <= 1'b0;
    end else begin
      CLAMP_ERR <= (LOAD && clamp) ? 1'b1 : CLR_ERR ? 1'b0 : CLAMP_ERR;
      if (change) begin
        DLY_CUR   <= eff;
        A         <= eff_m1[3:0];
        cnt       <= 5'd0;
        state     <= FILL;
        DLY_VALID <= 1'b0;
        BUSY      <= 1'b1;
      end else if (state == FILL && CE) begin
        cnt <= cnt_nxt;
        if (cnt_nxt == DLY_CUR) begin
          state     <= RUN;
          DLY_VALID <= 1'b1;
          BUSY      <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_srl_dly_ctrl.sv
// tb_srl_dly_ctrl: directed scenario tests for srl_dly_ctrl driving a behavioural 16-deep SRL
module tb_srl_dly_ctrl;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE = 1'b1;
  logic       LOAD = 1'b0;
  logic [4:0] DLY_REQ = 5'd0;
  logic       CLR_ERR = 1'b0;
  logic       SRL_CE;
  logic [3:0] A;
  logic [4:0] DLY_CUR;
  logic       DLY_VALID;
  logic       BUSY;
  logic       CLAMP_ERR;
  int         checks = 0;
  int         errors = 0;
  int         k = 0;
  logic [7:0] sr [16];
  logic [7:0] din;
  logic [7:0] dout;

  srl_dly_ctrl #(.DEFAULT_DLY(5)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .LOAD(LOAD), .DLY_REQ(DLY_REQ), .CLR_ERR(CLR_ERR),
    .SRL_CE(SRL_CE), .A(A), .DLY_CUR(DLY_CUR), .DLY_VALID(DLY_VALID), .BUSY(BUSY), .CLAMP_ERR(CLAMP_ERR)
  );

  always #5 CLK = ~CLK;

  // word k is presented on the k-th shift, so after n shifts tap t holds word n-1-t
  assign din  = k[7:0];
  assign dout = sr[A];
  always @(posedge CLK) begin
    if (SRL_CE) begin
      sr[0] <= din;
      for (int j = 1; j < 16; j++) sr[j] <= sr[j-1];
      k <= k + 1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; CE = 1'b1; LOAD = 1'b0;
    tick();
    checks++; if (A !== 4'd4) begin errors++; $display("FAIL reset_a got %0d exp 4", A); end
    checks++; if (DLY_CUR !== 5'd5) begin errors++; $display("FAIL reset_dly_cur got %0d exp 5", DLY_CUR); end
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL reset_busy got %0b exp 1", BUSY); end
    checks++; if (DLY_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", DLY_VALID); end
    checks++; if (CLAMP_ERR !== 1'b0) begin errors++; $display("FAIL reset_clamp got %0b exp 0", CLAMP_ERR); end
    RST = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (DLY_VALID !== (i == 5)) begin errors++; $display("FAIL reset_fill edge %0d got %0b exp %0b", i, DLY_VALID, i == 5); end
    end
    checks++; if (SRL_CE !== 1'b1) begin errors++; $display("FAIL srl_ce got %0b exp 1", SRL_CE); end
  endtask

  task automatic test_load12();
    logic [7:0] e;
    CE = 1'b1; LOAD = 1'b1; DLY_REQ = 5'd12;
    tick();
    LOAD = 1'b0;
    checks++; if (A !== 4'd11) begin errors++; $display("FAIL load12_a got %0d exp 11", A); end
    checks++; if (DLY_CUR !== 5'd12) begin errors++; $display("FAIL load12_dly got %0d exp 12", DLY_CUR); end
    checks++; if (DLY_VALID !== 1'b0) begin errors++; $display("FAIL load12_valid_drop got %0b exp 0", DLY_VALID); end
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL load12_busy got %0b exp 1", BUSY); end
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if (DLY_VALID !== (i == 12)) begin errors++; $display("FAIL load12_fill edge %0d got %0b exp %0b", i, DLY_VALID, i == 12); end
    end
    for (int i = 0; i < 6; i++) begin
      e = 8'(k - 12);
      checks++;
      if (!(DLY_VALID === 1'b1 && dout === e)) begin errors++; $display("FAIL load12_data valid %0b got %0d exp %0d", DLY_VALID, dout, e); end
      tick();
    end
  endtask

  task automatic test_clamp();
    LOAD = 1'b1; DLY_REQ = 5'd0;
    tick();
    checks++; if (DLY_CUR !== 5'd1 || A !== 4'd0) begin errors++; $display("FAIL clamp_low got %0d/%0d exp 1/0", DLY_CUR, A); end
    checks++; if (CLAMP_ERR !== 1'b1) begin errors++; $display("FAIL clamp_low_err got %0b exp 1", CLAMP_ERR); end
    DLY_REQ = 5'd20;
    tick();
    LOAD = 1'b0;
    checks++; if (DLY_CUR !== 5'd16 || A !== 4'd15) begin errors++; $display("FAIL clamp_high got %0d/%0d exp 16/15", DLY_CUR, A); end
    repeat (3) tick();
    checks++; if (CLAMP_ERR !== 1'b1) begin errors++; $display("FAIL clamp_hold got %0b exp 1", CLAMP_ERR); end
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    checks++; if (CLAMP_ERR !== 1'b0) begin errors++; $display("FAIL clamp_clear got %0b exp 0", CLAMP_ERR); end
    LOAD = 1'b1; DLY_REQ = 5'd25; CLR_ERR = 1'b1;
    tick();
    LOAD = 1'b0; CLR_ERR = 1'b0;
    checks++; if (CLAMP_ERR !== 1'b1) begin errors++; $display("FAIL clamp_set_wins got %0b exp 1", CLAMP_ERR); end
    checks++; if (A !== 4'd15 || BUSY !== 1'b1) begin errors++; $display("FAIL clamp_same_dly a %0d busy %0b exp 15/1", A, BUSY); end
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    checks++; if (CLAMP_ERR !== 1'b0) begin errors++; $display("FAIL clamp_clear2 got %0b exp 0", CLAMP_ERR); end
  endtask

  task automatic test_ce_toggle();
    int n = 0;
    CE = 1'b1; LOAD = 1'b1; DLY_REQ = 5'd8;
    tick();
    LOAD = 1'b0;
    for (int i = 0; i < 18; i++) begin
      CE = (i % 2 == 0);
      if (CE) n++;
      tick();
      checks++;
      if (DLY_VALID !== (n >= 8)) begin errors++; $display("FAIL toggle_fill cycle %0d got %0b exp %0b", i, DLY_VALID, n >= 8); end
    end
    CE = 1'b1; LOAD = 1'b1; DLY_REQ = 5'd8;
    tick();
    LOAD = 1'b0;
    checks++; if (BUSY !== 1'b0 || DLY_VALID !== 1'b1) begin errors++; $display("FAIL same_load busy %0b valid %0b exp 0/1", BUSY, DLY_VALID); end
    tick();
    checks++; if (BUSY !== 1'b0 || A !== 4'd7) begin errors++; $display("FAIL same_load_after busy %0b a %0d exp 0/7", BUSY, A); end
  endtask

  task automatic test_load_collide();
    CE = 1'b1; LOAD = 1'b1; DLY_REQ = 5'd16;
    tick();
    DLY_REQ = 5'd8;
    tick();
    LOAD = 1'b0;
    repeat (7) tick();
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL collide_pre busy got %0b exp 1", BUSY); end
    LOAD = 1'b1; DLY_REQ = 5'd3;
    tick();
    LOAD = 1'b0;
    checks++; if (BUSY !== 1'b1 || DLY_VALID !== 1'b0) begin errors++; $display("FAIL collide_stay busy %0b valid %0b exp 1/0", BUSY, DLY_VALID); end
    checks++; if (DLY_CUR !== 5'd3 || A !== 4'd2) begin errors++; $display("FAIL collide_dly got %0d/%0d exp 3/2", DLY_CUR, A); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (DLY_VALID !== (i == 3)) begin errors++; $display("FAIL collide_fill edge %0d got %0b exp %0b", i, DLY_VALID, i == 3); end
    end
  endtask

  task automatic test_async_reset();
    CE = 1'b1; LOAD = 1'b1; DLY_REQ = 5'd10;
    tick();
    LOAD = 1'b0;
    repeat (3) tick();
    LOAD = 1'b1; DLY_REQ = 5'd12;
    #2 RST = 1'b1;
    #1;
    checks++; if (A !== 4'd4 || DLY_CUR !== 5'd5) begin errors++; $display("FAIL async_dly got %0d/%0d exp 4/5", A, DLY_CUR); end
    checks++; if (BUSY !== 1'b1 || DLY_VALID !== 1'b0) begin errors++; $display("FAIL async_state busy %0b valid %0b exp 1/0", BUSY, DLY_VALID); end
    tick();
    LOAD = 1'b0;
    RST = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (DLY_VALID !== (i == 5)) begin errors++; $display("FAIL async_refill edge %0d got %0b exp %0b", i, DLY_VALID, i == 5); end
    end
    checks++; if (DLY_CUR !== 5'd5) begin errors++; $display("FAIL async_load_lost got %0d exp 5", DLY_CUR); end
  endtask

  initial begin
    test_reset();
    test_load12();
    test_clamp();
    test_ce_toggle();
    test_load_collide();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
